fb_rect_fill: RTL and testbench

- Upstream neighbour of the LCD scan-out stage; a rectangle-fill engine that writes 4-bit palette indices into the 640x480 framebuffer RAM.
- The scan-out stage reads the same RAM through its own port.
- Accepts one rectangle command per valid/ready handshake.
- Emits one pixel write per clock in raster order, then pulses done.
- Used by game logic for background clears, track tiles and HUD boxes.

---
 rtl/screen_pkg.sv | 49 ++++
 rtl/fb_addr_gen.sv | 59 +++++
 rtl/fb_rect_fill.sv | 136 +++++++++++++
 tb/tb_fb_rect_fill.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared framebuffer geometry, pixel/address types and fill-engine state.
// Also used by the LCD scan-out stage.
package screen_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 4;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [9:0]        coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t w;
        coord_t h;
        pix_t   color;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

    localparam addr_t  H_STEP = addr_t'(H_RES);
    localparam coord_t H_LIM  = coord_t'(H_RES);
    localparam coord_t V_LIM  = coord_t'(V_RES);

    // y*640 + x built from shifts and adds, no multiplier
    function automatic addr_t row_base(input coord_t y, input coord_t x);
        addr_t ya;
        ya = addr_t'(y);
        return (ya << 9) + (ya << 7) + addr_t'(x);
    endfunction

    // Length of a span starting at s clipped to [0, lim-1]
    function automatic coord_t clip_len(input coord_t s, input coord_t len,
                                        input coord_t lim);
        coord_t room;
        if (s >= lim)
            return '0;
        room = lim - s;
        return (len < room) ? len : room;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster-order address generator: row/col counters plus running row base.
// o_addr is the registered address of the current write; o_last marks the final pixel.
module fb_addr_gen
    import screen_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  addr_t  i_base,
    input  coord_t i_w,
    input  coord_t i_h,
    input  logic   i_step,
    output addr_t  o_addr,
    output logic   o_last
);

    coord_t r_col;
    coord_t r_row;
    coord_t r_w;
    coord_t r_h;
    addr_t  r_row_base;
    addr_t  r_addr;

    logic w_eol;

    assign w_eol  = (r_col == r_w - 10'd1);
    assign o_last = w_eol && (r_row == r_h - 10'd1);
    assign o_addr = r_addr;

    // Load a new rectangle origin, or advance one pixel in raster order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_load) begin
            r_col      <= '0;
            r_row      <= '0;
            r_w        <= i_w;
            r_h        <= i_h;
            r_row_base <= i_base;
            r_addr     <= i_base;
        end else if (i_step) begin
            if (w_eol) begin
                r_col      <= '0;
                r_row      <= r_row + 10'd1;
                r_row_base <= r_row_base + H_STEP;
                r_addr     <= r_row_base + H_STEP;
            end else begin
                r_col  <= r_col + 10'd1;
                r_addr <= r_addr + addr_t'(1);
            end
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: one palette write per clock in raster order, then done.
// Optional clipping to the visible screen when FB_RECT_CLIP_EN is defined.
module fb_rect_fill
    import screen_pkg::*;
(
    input  logic              pixel_clock,
    input  logic              pixel_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [PIX_W-1:0]  cmd_color,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    fill_state_t r_state;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_wr_en;
    pix_t        r_color;

    logic   w_go;
    addr_t  w_base;
    coord_t w_w;
    coord_t w_h;
    pix_t   w_color;
    logic   w_last;
    logic   w_empty;

`ifdef FB_RECT_CLIP_EN
    rect_cmd_t r_cmd;
    logic      r_pend;
    logic      w_acc;

    assign w_acc   = (r_state == IDLE) && r_ready && cmd_valid;
    assign w_go    = r_pend;
    assign w_base  = row_base(r_cmd.y, r_cmd.x);
    assign w_w     = clip_len(r_cmd.x, r_cmd.w, H_LIM);
    assign w_h     = clip_len(r_cmd.y, r_cmd.h, V_LIM);
    assign w_color = r_cmd.color;

    // Latch the raw command; clipping is resolved one cycle later
    always_ff @(posedge pixel_clock) begin
        if (pixel_reset) begin
            r_pend <= 1'b0;
            r_cmd  <= '0;
        end else begin
            r_pend <= w_acc;
            if (w_acc)
                r_cmd <= '{x: cmd_x, y: cmd_y, w: cmd_w,
                           h: cmd_h, color: cmd_color};
        end
    end
`else
    assign w_go    = (r_state == IDLE) && r_ready && cmd_valid;
    assign w_base  = row_base(cmd_y, cmd_x);
    assign w_w     = cmd_w;
    assign w_h     = cmd_h;
    assign w_color = cmd_color;
`endif

    assign w_empty = (w_w == '0) || (w_h == '0);

    fb_addr_gen u_addr (
        .clk    (pixel_clock),
        .rst    (pixel_reset),
        .i_load (w_go),
        .i_base (w_base),
        .i_w    (w_w),
        .i_h    (w_h),
        .i_step (r_state == FILL),
        .o_addr (wr_addr),
        .o_last (w_last)
    );

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_en     = r_wr_en;
    assign wr_data   = r_color;

    // Control FSM with registered handshake, strobe and status outputs
    always_ff @(posedge pixel_clock) begin
        if (pixel_reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            r_color <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
`ifdef FB_RECT_CLIP_EN
                    if (w_acc)
                        r_ready <= 1'b0;
`endif
                    if (w_go) begin
                        r_ready <= 1'b0;
                        r_color <= w_color;
                        if (w_empty) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= FILL;
                            r_busy  <= 1'b1;
                            r_wr_en <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill against a raster-order reference model.
// Clip-mode expectations are enabled when FB_RECT_CLIP_EN is defined.
module tb_fb_rect_fill;
    import screen_pkg::*;

`ifdef FB_RECT_CLIP_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic              pixel_clock = 1'b0;
    logic              pixel_reset = 1'b1;
    logic              cmd_valid   = 1'b0;
    logic              cmd_ready;
    logic [9:0]        cmd_x = '0;
    logic [9:0]        cmd_y = '0;
    logic [9:0]        cmd_w = '0;
    logic [9:0]        cmd_h = '0;
    logic [PIX_W-1:0]  cmd_color = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              busy;
    logic              done;

    fb_rect_fill dut (
        .pixel_clock (pixel_clock),
        .pixel_reset (pixel_reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 pixel_clock = ~pixel_clock;

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_bad = 0;
    wr_t  wq[$];
    int   dq[$];
    int   rq[$];
    logic prev_rdy = 1'b1;

    always @(posedge pixel_clock) cyc++;

    // Observe the write port, done pulses and ready rising edges
    always @(negedge pixel_clock) begin
        if (wr_en === 1'b1)
            wq.push_back('{cyc, int'(wr_addr), int'(wr_data)});
        if (done === 1'b1)
            dq.push_back(cyc);
        if (cmd_ready === 1'b1 && prev_rdy !== 1'b1)
            rq.push_back(cyc);
        if (!pixel_reset && busy !== wr_en)
            busy_bad++;
        prev_rdy = cmd_ready;
    end

    // Reference: expected writes and done cycle for a command accepted at acc
    function automatic void model(input int x, input int y, input int w,
                                  input int h, input int col, input int acc,
                                  output wr_t q[$], output int dcyc);
        int ew;
        int eh;
        ew = w;
        eh = h;
`ifdef FB_RECT_CLIP_EN
        if (x >= H_RES || y >= V_RES) begin
            ew = 0;
            eh = 0;
        end else begin
            if (ew > H_RES - x) ew = H_RES - x;
            if (eh > V_RES - y) eh = V_RES - y;
        end
`endif
        q = {};
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                q.push_back('{acc + 1 + PIPE + r * ew + c,
                              (y + r) * H_RES + x + c, col});
        dcyc = acc + 1 + PIPE + ew * eh;
    endfunction

    task automatic set_cmd(input int x, input int y, input int w,
                           input int h, input int col);
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = PIX_W'(col);
    endtask

    task automatic scramble();
        cmd_x     = 10'($urandom);
        cmd_y     = 10'($urandom);
        cmd_w     = 10'($urandom);
        cmd_h     = 10'($urandom);
        cmd_color = PIX_W'($urandom);
    endtask

    // Present a command and return the cycle in which it was accepted
    task automatic drive(input int x, input int y, input int w, input int h,
                         input int col, output int acc);
        @(negedge pixel_clock);
        set_cmd(x, y, w, h, col);
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge pixel_clock);
        end
        @(posedge pixel_clock);
        #1;
        cmd_valid = 1'b0;
        scramble();
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept: cmd_ready never seen, need 1");
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (dq.size() < n && k < budget) begin
            @(negedge pixel_clock);
            #1;
            k++;
        end
        checks++;
        if (dq.size() < n) begin
            errors++;
            $display("FAIL done_timeout: got %0d pulses need %0d",
                     dq.size(), n);
        end
        repeat (3) @(negedge pixel_clock);
        #1;
    endtask

    task automatic test_single(input string nm, input int x, input int y,
                               input int w, input int h, input int col);
        wr_t exp[$];
        int  acc;
        int  dcyc;
        int  shown;
        wq.delete();
        dq.delete();
        rq.delete();
        drive(x, y, w, h, col, acc);
        if (acc < 0) return;
        model(x, y, w, h, col, acc, exp, dcyc);
        wait_done(1, exp.size() + 40);
        checks++;
        if (wq.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes need %0d",
                     nm, wq.size(), exp.size());
        end
        shown = 0;
        for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] != exp[i]) begin
                errors++;
                if (shown < 5)
                    $display("FAIL %s_wr%0d: got c%0d a%0d d%0d need c%0d a%0d d%0d",
                             nm, i, wq[i].c, wq[i].a, wq[i].d,
                             exp[i].c, exp[i].a, exp[i].d);
                shown++;
            end
        end
        checks++;
        if (dq.size() !== 1 || dq[0] !== dcyc) begin
            errors++;
            $display("FAIL %s_done: got %0d pulses first %0d need 1 at %0d",
                     nm, dq.size(), (dq.size() > 0) ? dq[0] : -1, dcyc);
        end
        checks++;
        if (rq.size() !== 1 || rq[0] !== dcyc + 1) begin
            errors++;
            $display("FAIL %s_ready: got %0d rises first %0d need 1 at %0d",
                     nm, rq.size(), (rq.size() > 0) ? rq[0] : -1, dcyc + 1);
        end
    endtask

    task automatic test_reset();
        pixel_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pixel_clock);
            checks++;
            if (cmd_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
                errors++;
                $display("FAIL reset%0d: got rdy%b en%b busy%b done%b a%0d d%0d need 1 0 0 0 0 0",
                         i, cmd_ready, wr_en, busy, done, wr_addr, wr_data);
            end
        end
        pixel_reset = 1'b0;
        repeat (2) @(negedge pixel_clock);
        checks++;
        if (cmd_ready !== 1'b1 || wr_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle: got rdy%b en%b done%b need 1 0 0",
                     cmd_ready, wr_en, done);
        end
    endtask

    task automatic test_basic();
        busy_bad = 0;
        test_single("basic", 10, 2, 3, 2, 5);
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL busy_track: got %0d bad cycles need 0", busy_bad);
        end
    endtask

    task automatic test_degenerate();
        test_single("w0", 5, 5, 0, 7, 3);
        test_single("h0", 3, 3, 4, 0, 9);
        test_single("corner", 639, 479, 1, 1, 12);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int w;
            int h;
            w = int'($urandom_range(1, 24));
            h = int'($urandom_range(1, 8));
            test_single("rand",
                        int'($urandom_range(0, H_RES - w)),
                        int'($urandom_range(0, V_RES - h)),
                        w, h, int'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_back_to_back();
        wr_t ea[$];
        wr_t eb[$];
        int  acc_a;
        int  acc_b;
        int  da;
        int  db;
        wq.delete();
        dq.delete();
        rq.delete();
        @(negedge pixel_clock);
        set_cmd(100, 50, 4, 3, 7);
        cmd_valid = 1'b1;
        acc_a = -1;
        for (int i = 0; i < 64 && acc_a < 0; i++) begin
            if (cmd_ready === 1'b1) acc_a = cyc;
            else @(negedge pixel_clock);
        end
        @(posedge pixel_clock);
        #1;
        set_cmd(200, 300, 5, 2, 11);
        acc_b = -1;
        for (int i = 0; i < 64 && acc_b < 0; i++) begin
            @(negedge pixel_clock);
            if (cmd_ready === 1'b1) acc_b = cyc;
        end
        @(posedge pixel_clock);
        #1;
        cmd_valid = 1'b0;
        scramble();
        wait_done(2, 60);
        model(100, 50, 4, 3, 7, acc_a, ea, da);
        model(200, 300, 5, 2, 11, acc_b, eb, db);
        checks++;
        if (acc_a < 0 || acc_b !== acc_a + 12 + 2 + PIPE) begin
            errors++;
            $display("FAIL b2b_accept: got %0d need %0d",
                     acc_b, acc_a + 14 + PIPE);
        end
        foreach (eb[i]) ea.push_back(eb[i]);
        checks++;
        if (wq.size() !== ea.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d need %0d",
                     wq.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wq.size(); i++) begin
            checks++;
            if (wq[i] != ea[i]) begin
                errors++;
                $display("FAIL b2b_wr%0d: got c%0d a%0d d%0d need c%0d a%0d d%0d",
                         i, wq[i].c, wq[i].a, wq[i].d,
                         ea[i].c, ea[i].a, ea[i].d);
            end
        end
        checks++;
        if (dq.size() !== 2 || dq[0] !== da || dq[1] !== db) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses need 2 at %0d %0d",
                     dq.size(), da, db);
        end
    endtask

    task automatic test_reset_mid_fill();
        int acc;
        int k;
        wq.delete();
        dq.delete();
        rq.delete();
        drive(0, 0, H_RES, V_RES, 6, acc);
        k = 0;
        while (wq.size() < 1000 && k < 1200) begin
            @(negedge pixel_clock);
            #1;
            k++;
        end
        checks++;
        if (wq.size() !== 1000) begin
            errors++;
            $display("FAIL midrst_reach: got %0d writes need 1000", wq.size());
        end
        pixel_reset = 1'b1;
        @(posedge pixel_clock);
        #1;
        pixel_reset = 1'b0;
        @(negedge pixel_clock);
        checks++;
        if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_out: got en%b done%b busy%b rdy%b need 0 0 0 1",
                     wr_en, done, busy, cmd_ready);
        end
        repeat (10) @(negedge pixel_clock);
        #1;
        checks++;
        if (dq.size() !== 0 || wq.size() !== 1000) begin
            errors++;
            $display("FAIL midrst_quiet: got %0d dones %0d writes need 0 1000",
                     dq.size(), wq.size());
        end
        test_single("after_rst", 20, 30, 6, 3, 2);
    endtask

`ifdef FB_RECT_CLIP_EN
    task automatic test_clip();
        test_single("clip", 630, 478, 20, 5, 4);
        test_single("clip_x", 700, 10, 5, 5, 1);
        test_single("clip_y", 10, 500, 5, 5, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_degenerate();
        test_random();
        test_back_to_back();
        test_reset_mid_fill();
`ifdef FB_RECT_CLIP_EN
        test_clip();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
